// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with a one-entry skid buffer, freeze/flush
// control, occupancy reporting and a saturating stall-cycle counter.
module pipe_skid_reg #(
    parameter int unsigned       DATA_W     = 64,
    parameter logic [DATA_W-1:0] FLUSH_DATA = '0,
    parameter int unsigned       CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic              main_valid_q, main_valid_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic              skid_valid_q, skid_valid_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic accept;
    logic consume;
    logic stall_inc;

    // Handshake terms; in_ready comes only from registered state and freeze.
    always_comb begin
        in_ready = !skid_valid_q && !freeze;
        accept   = in_valid && in_ready;
        consume  = main_valid_q && out_ready && !freeze;
    end

    // Next state of the main and skid entries: flush beats freeze beats normal.
    always_comb begin
        main_data_d  = main_data_q;
        main_valid_d = main_valid_q;
        skid_data_d  = skid_data_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
            main_data_d  = FLUSH_DATA;
        end else if (!freeze) begin
            if (skid_valid_q) begin
                if (consume) begin
                    main_data_d  = skid_data_q;
                    skid_valid_d = 1'b0;
                end
            end else if (accept && (!main_valid_q || consume)) begin
                main_data_d  = in_data;
                main_valid_d = 1'b1;
            end else if (accept) begin
                skid_data_d  = in_data;
                skid_valid_d = 1'b1;
            end else if (consume) begin
                main_valid_d = 1'b0;
            end
        end
    end

    // Stall counter: counts held-but-not-leaving cycles, saturates at all-ones.
    always_comb begin
        stall_inc   = main_valid_q && (!out_ready || freeze) && !flush;
        stall_cnt_d = stall_cnt_q;
        if (stall_inc && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_data_q  <= FLUSH_DATA;
            main_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_valid_q <= 1'b0;
            stall_cnt_q  <= '0;
        end else begin
            main_data_q  <= main_data_d;
            main_valid_q <= main_valid_d;
            skid_data_q  <= skid_data_d;
            skid_valid_q <= skid_valid_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    // Output view of the held state.
    always_comb begin
        out_valid = main_valid_q;
        out_data  = main_data_q;
        occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};
        stall_cnt = stall_cnt_q;
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Testbench for pipe_skid_reg: directed scenarios plus randomized
// traffic checked against a queue-based model of the stage.
module tb_pipe_skid_reg;

    localparam int          DW   = 16;
    localparam int          CW   = 3;
    localparam logic [15:0] FLSH = 16'hDEAD;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          freeze = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready = 1'b0;
    logic [1:0]    occupancy;
    logic [CW-1:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mq[$];
    logic [DW-1:0] mlast = FLSH;
    int            mcnt = 0;

    pipe_skid_reg #(
        .DATA_W(DW),
        .FLUSH_DATA(FLSH),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .freeze(freeze),
        .flush(flush),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_ready(out_ready),
        .occupancy(occupancy),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // Reference: the stage is a FIFO of at most two beats.
    task automatic model_edge();
        bit has;
        bit acc;
        bit con;
        if (rst) begin
            mq.delete();
            mlast = FLSH;
            mcnt = 0;
        end else if (flush) begin
            mq.delete();
            mlast = FLSH;
        end else begin
            has = mq.size() > 0;
            acc = in_valid && mq.size() < 2 && !freeze;
            con = has && out_ready && !freeze;
            if (has && (!out_ready || freeze) && mcnt < 7) mcnt++;
            if (con) mlast = mq.pop_front();
            if (acc) mq.push_back(in_data);
        end
    endtask

    function automatic logic [22:0] exp_vec();
        logic [DW-1:0] d;
        d = (mq.size() > 0) ? mq[0] : mlast;
        return {(mq.size() < 2) && !freeze, mq.size() > 0, d,
                2'(mq.size()), 3'(mcnt)};
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        rst = 1'b0;
        freeze = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({in_ready, out_valid, out_data, occupancy, stall_cnt} !==
            {1'b1, 1'b0, FLSH, 2'd0, 3'd0}) begin
            errors++;
            $display("FAIL reset: got rdy=%b v=%b d=%h occ=%0d st=%0d want 1 0 dead 0 0",
                     in_ready, out_valid, out_data, occupancy, stall_cnt);
        end
    endtask

    task automatic test_stream();
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_data = 16'(i);
            step();
            checks++;
            if ({out_valid, out_data, in_ready, stall_cnt} !==
                {1'b1, 16'(i), 1'b1, 3'd0} || occupancy > 2'd1) begin
                errors++;
                $display("FAIL stream[%0d]: got v=%b d=%h rdy=%b st=%0d occ=%0d want 1 %h 1 0 <=1",
                         i, out_valid, out_data, in_ready, stall_cnt, occupancy, 16'(i));
            end
        end
        in_valid = 1'b0;
        step();
        checks++;
        if ({out_valid, out_data, occupancy} !== {1'b0, 16'd4, 2'd0}) begin
            errors++;
            $display("FAIL stream_drain: got v=%b d=%h occ=%0d want 0 0004 0",
                     out_valid, out_data, occupancy);
        end
    endtask

    task automatic test_skid();
        do_reset();
        in_valid = 1'b1;
        in_data = 16'hA;
        step();
        checks++;
        if ({occupancy, in_ready, out_data} !== {2'd1, 1'b1, 16'hA}) begin
            errors++;
            $display("FAIL skid_a: got occ=%0d rdy=%b d=%h want 1 1 000a",
                     occupancy, in_ready, out_data);
        end
        in_data = 16'hB;
        step();
        checks++;
        if ({occupancy, in_ready, out_data, stall_cnt} !==
            {2'd2, 1'b0, 16'hA, 3'd1}) begin
            errors++;
            $display("FAIL skid_b: got occ=%0d rdy=%b d=%h st=%0d want 2 0 000a 1",
                     occupancy, in_ready, out_data, stall_cnt);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        checks++;
        if ({occupancy, in_ready, out_valid, out_data} !==
            {2'd1, 1'b1, 1'b1, 16'hB}) begin
            errors++;
            $display("FAIL skid_rel1: got occ=%0d rdy=%b v=%b d=%h want 1 1 1 000b",
                     occupancy, in_ready, out_valid, out_data);
        end
        step();
        checks++;
        if ({occupancy, out_valid} !== {2'd0, 1'b0}) begin
            errors++;
            $display("FAIL skid_rel2: got occ=%0d v=%b want 0 0", occupancy, out_valid);
        end
    endtask

    task automatic test_freeze();
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data = 16'hC;
        step();
        in_valid = 1'b0;
        freeze = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            checks++;
            if ({out_valid, out_data, in_ready, stall_cnt} !==
                {1'b1, 16'hC, 1'b0, 3'(k)}) begin
                errors++;
                $display("FAIL freeze[%0d]: got v=%b d=%h rdy=%b st=%0d want 1 000c 0 %0d",
                         k, out_valid, out_data, in_ready, stall_cnt, k);
            end
        end
        freeze = 1'b0;
        step();
        checks++;
        if ({out_valid, stall_cnt, in_ready} !== {1'b0, 3'd3, 1'b1}) begin
            errors++;
            $display("FAIL freeze_rel: got v=%b st=%0d rdy=%b want 0 3 1",
                     out_valid, stall_cnt, in_ready);
        end
    endtask

    task automatic test_flush();
        do_reset();
        in_valid = 1'b1;
        in_data = 16'hD;
        step();
        in_data = 16'hE;
        step();
        flush = 1'b1;
        freeze = 1'b1;
        in_data = 16'hF;
        step();
        checks++;
        if ({out_valid, occupancy, out_data, stall_cnt} !==
            {1'b0, 2'd0, FLSH, 3'd1}) begin
            errors++;
            $display("FAIL flush: got v=%b occ=%0d d=%h st=%0d want 0 0 dead 1",
                     out_valid, occupancy, out_data, stall_cnt);
        end
        idle_inputs();
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if ({out_valid, out_data} !== {1'b0, FLSH}) begin
                errors++;
                $display("FAIL flush_after[%0d]: got v=%b d=%h want 0 dead",
                         k, out_valid, out_data);
            end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        in_valid = 1'b1;
        in_data = 16'h55;
        step();
        in_valid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            checks++;
            if (stall_cnt !== 3'((k > 7) ? 7 : k)) begin
                errors++;
                $display("FAIL sat[%0d]: got st=%0d want %0d",
                         k, stall_cnt, (k > 7) ? 7 : k);
            end
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({stall_cnt, out_valid, out_data} !== {3'd0, 1'b0, FLSH}) begin
            errors++;
            $display("FAIL sat_rst: got st=%0d v=%b d=%h want 0 0 dead",
                     stall_cnt, out_valid, out_data);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        in_valid = 1'b1;
        in_data = 16'h01;
        step();
        in_data = 16'h02;
        step();
        rst = 1'b1;
        in_data = 16'h11;
        step();
        checks++;
        if ({occupancy, in_ready, out_valid} !== {2'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL rst_mid: got occ=%0d rdy=%b v=%b want 0 1 0",
                     occupancy, in_ready, out_valid);
        end
        rst = 1'b0;
        in_data = 16'h22;
        step();
        checks++;
        if ({out_valid, out_data} !== {1'b1, 16'h22}) begin
            errors++;
            $display("FAIL rst_mid_first: got v=%b d=%h want 1 0022",
                     out_valid, out_data);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(99) < 1);
            flush = ($urandom_range(99) < 3);
            freeze = ($urandom_range(99) < 12);
            in_valid = ($urandom_range(99) < 65);
            in_data = 16'($urandom);
            out_ready = ($urandom_range(99) < 55);
            #1;
            checks++;
            if (in_ready !== ((mq.size() < 2) && !freeze)) begin
                errors++;
                $display("FAIL rand_rdy[%0d]: got %b want %b",
                         n, in_ready, (mq.size() < 2) && !freeze);
            end
            step();
            checks++;
            if ({in_ready, out_valid, out_data, occupancy, stall_cnt} !== exp_vec()) begin
                errors++;
                $display("FAIL rand[%0d]: got %h want %h", n,
                         {in_ready, out_valid, out_data, occupancy, stall_cnt}, exp_vec());
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_skid();
        test_freeze();
        test_flush();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
